uart2wifi_core: RTL and testbench



---
 rtl/uart2wifi_pkg.sv | 26 ++
 rtl/uart2wifi_link.sv | 216 +++++++++++++++++++++
 rtl/uart2wifi_core.sv | 71 +++++++
 tb/tb_uart2wifi_core.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart2wifi_pkg.sv
// Shared types and helpers for the uart2wifi byte bridge.
package uart2wifi_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // Bit period in core clocks, truncated.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart2wifi_link.sv
// One direction of the bridge: 8N1 receiver -> byte FIFO -> 8N1 transmitter.
module uart2wifi_link
    import uart2wifi_pkg::*;
#(
    parameter int unsigned RX_CLKS    = 434,
    parameter int unsigned TX_CLKS    = 434,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    output logic tx_out,
    output logic overflow,
    output logic frame_err,
    output logic busy
);

    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned CW  = $clog2((RX_CLKS > TX_CLKS) ? RX_CLKS : TX_CLKS) + 1;
    localparam logic [CW-1:0] RX_HALF = CW'(RX_CLKS / 2 - 1);
    localparam logic [CW-1:0] RX_LAST = CW'(RX_CLKS - 1);
    localparam logic [CW-1:0] TX_LAST = CW'(TX_CLKS - 1);

    logic          sync1_q, sync2_q, prev_q;
    rx_state_e     rx_state_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    byte_t         rx_sh_q;
    logic          push_q;
    logic          frame_err_q;

    byte_t         mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic          overflow_q;
    logic          empty_c, full_c, push_ok_c, pop_c;
    byte_t         rd_data_c;

    tx_state_e     tx_state_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_bit_q;
    byte_t         tx_sh_q;
    logic          tx_q;
    logic          busy_q;

    assign empty_c   = (wr_ptr_q == rd_ptr_q);
    assign full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok_c = push_q && !full_c;
    assign rd_data_c = mem_q[rd_ptr_q[AW-1:0]];
    // Pop on leaving idle, or at the end of a stop bit so frames run back-to-back.
    assign pop_c     = !empty_c &&
                       ((tx_state_q == TX_IDLE) ||
                        ((tx_state_q == TX_STOP) && (tx_cnt_q == TX_LAST)));

    // Receiver: synchronizer, falling-edge detect, mid-bit sampling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            push_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (prev_q && !sync2_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == RX_HALF) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == RX_LAST) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {sync2_q, rx_sh_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == RX_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                        if (sync2_q) begin
                            push_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= rx_sh_q;
        end
    end

    // FIFO pointers and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok_c) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (push_q && full_c) begin
                overflow_q <= 1'b1;
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Transmitter: start, 8 data bits LSB first, one stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            busy_q <= !empty_c || (tx_state_q != TX_IDLE);
            case (tx_state_q)
                TX_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop_c) begin
                        tx_sh_q    <= rd_data_c;
                        tx_q       <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == TX_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_q       <= tx_sh_q[0];
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == TX_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_bit_q <= tx_bit_q + 3'd1;
                            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                            tx_q     <= tx_sh_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == TX_LAST) begin
                        tx_cnt_q <= '0;
                        if (pop_c) begin
                            tx_sh_q    <= rd_data_c;
                            tx_q       <= 1'b0;
                            tx_state_q <= TX_START;
                        end else begin
                            tx_state_q <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CW'(1);
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign tx_out    = tx_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: rtl/uart2wifi_core.sv
// Top of the uart2wifi bridge: two independent links, host->wifi and wifi->host.
module uart2wifi_core
    import uart2wifi_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned BAUD            = 115200,
    parameter int unsigned FIFO_DEPTH      = 16,
    // Non-zero overrides the transmitter bit period (clocks); 0 uses CLK_HZ/BAUD.
    parameter int unsigned TX_CLKS_PER_BIT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic host_rx,
    output logic host_tx,
    input  logic wifi_rx,
    output logic wifi_tx,
    output logic h2w_overflow,
    output logic w2h_overflow,
    output logic frame_err,
    output logic busy
);

    localparam int unsigned RX_CLKS = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned TX_CLKS = (TX_CLKS_PER_BIT != 0) ? TX_CLKS_PER_BIT : RX_CLKS;

    logic h2w_ferr, w2h_ferr, h2w_busy, w2h_busy;
    logic frame_err_q, busy_q;

    uart2wifi_link #(
        .RX_CLKS   (RX_CLKS),
        .TX_CLKS   (TX_CLKS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_h2w (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_in    (host_rx),
        .tx_out   (wifi_tx),
        .overflow (h2w_overflow),
        .frame_err(h2w_ferr),
        .busy     (h2w_busy)
    );

    uart2wifi_link #(
        .RX_CLKS   (RX_CLKS),
        .TX_CLKS   (TX_CLKS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_w2h (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_in    (wifi_rx),
        .tx_out   (host_tx),
        .overflow (w2h_overflow),
        .frame_err(w2h_ferr),
        .busy     (w2h_busy)
    );

    // Merge per-direction status into the shared flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            frame_err_q <= h2w_ferr | w2h_ferr;
            busy_q      <= h2w_busy | w2h_busy;
        end
    end

    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart2wifi_core.sv
// Bench for uart2wifi_core: serial drivers, per-line frame decoders checked against
// an expected-byte model, plus literal spot checks.
module tb_uart2wifi_core;

    localparam int CPB     = 434;   // 50 MHz / 115200
    localparam int O_RXCPB = 10;    // 50 MHz / 5 Mbaud on the overflow instance
    localparam int O_TXCPB = 200;   // slowed transmitter on the overflow instance

    logic clk = 1'b0;
    logic rst_n;
    logic m_host_rx, m_wifi_rx, m_host_tx, m_wifi_tx, m_h2w, m_w2h, m_ferr, m_busy;
    logic o_host_rx, o_wifi_rx, o_host_tx, o_wifi_tx, o_h2w, o_w2h, o_ferr, o_busy;

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart2wifi_core dut (
        .clk(clk), .rst_n(rst_n),
        .host_rx(m_host_rx), .host_tx(m_host_tx),
        .wifi_rx(m_wifi_rx), .wifi_tx(m_wifi_tx),
        .h2w_overflow(m_h2w), .w2h_overflow(m_w2h),
        .frame_err(m_ferr), .busy(m_busy)
    );

    uart2wifi_core #(
        .CLK_HZ(50_000_000), .BAUD(5_000_000), .FIFO_DEPTH(16), .TX_CLKS_PER_BIT(O_TXCPB)
    ) dut_ovf (
        .clk(clk), .rst_n(rst_n),
        .host_rx(o_host_rx), .host_tx(o_host_tx),
        .wifi_rx(o_wifi_rx), .wifi_tx(o_wifi_tx),
        .h2w_overflow(o_h2w), .w2h_overflow(o_w2h),
        .frame_err(o_ferr), .busy(o_busy)
    );

    // Model: expected bytes per output line (0 m_wifi_tx, 1 m_host_tx, 2 o_wifi_tx, 3 o_host_tx)
    logic [7:0] exp_mem [4][64];
    int         exp_wr [4];
    int         exp_rd [4];
    int         starts [4];
    int         last_start [4];
    logic [7:0] last_byte [4];
    logic [9:0] last_frame [4];
    logic       exp_h2w [2];
    logic       exp_w2h [2];
    logic       exp_ferr [2];
    int         n_tests = 0;
    int         n_fail  = 0;

    function automatic logic line_val(input int idx);
        case (idx)
            0:       return m_wifi_tx;
            1:       return m_host_tx;
            2:       return o_wifi_tx;
            default: return o_host_tx;
        endcase
    endfunction

    task automatic set_line(input int idx, input logic v);
        case (idx)
            0:       m_host_rx = v;
            1:       m_wifi_rx = v;
            2:       o_host_rx = v;
            default: o_wifi_rx = v;
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic expect_byte(input int idx, input logic [7:0] b);
        exp_mem[idx][exp_wr[idx]] = b;
        exp_wr[idx]++;
    endtask

    // Drive one 8N1 frame; t0 is the cycle the start bit was applied.
    task automatic send_byte(input int idx, input logic [7:0] b, input int cpb,
                             input logic stop, output int t0);
        @(negedge clk);
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      set_line(idx, 1'b0);
            else if (i == 9) set_line(idx, stop);
            else             set_line(idx, b[i-1]);
            repeat (cpb) @(negedge clk);
        end
        set_line(idx, 1'b1);
    endtask

    // Drive start and data bits 0..3, stopping halfway through data bit 4.
    task automatic send_partial(input int idx, input logic [7:0] b, input int cpb);
        @(negedge clk);
        set_line(idx, 1'b0);
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            set_line(idx, b[i]);
            repeat (cpb) @(negedge clk);
        end
        set_line(idx, b[4]);
        repeat (cpb / 2) @(negedge clk);
    endtask

    // Decode each frame on a line; every cycle of every bit must match the expected level.
    task automatic mon(input int idx, input int cpb);
        logic [9:0] frm;
        logic [9:0] exp_f;
        logic [7:0] exp_b;
        logic       have_exp;
        int         bad;
        forever begin
            @(negedge clk);
            if (line_val(idx) === 1'b0) begin
                last_start[idx] = cyc;
                starts[idx]++;
                have_exp = (exp_rd[idx] != exp_wr[idx]);
                exp_b    = have_exp ? exp_mem[idx][exp_rd[idx]] : 8'h00;
                exp_f    = {1'b1, exp_b, 1'b0};
                bad      = 0;
                frm      = '0;
                for (int j = 0; j < 10 * cpb; j++) begin
                    if (j > 0) @(negedge clk);
                    if (line_val(idx) !== exp_f[j / cpb]) bad++;
                    if ((j % cpb) == (cpb / 2)) frm[j / cpb] = line_val(idx);
                end
                last_frame[idx] = frm;
                last_byte[idx]  = frm[8:1];
                n_tests++;
                if (!have_exp) begin
                    n_fail++;
                    $display("FAIL frame_unexpected line=%0d: got byte %02h expected no frame",
                             idx, frm[8:1]);
                end else begin
                    if (bad != 0) begin
                        n_fail++;
                        $display("FAIL frame line=%0d: got %02h (frame %010b, %0d bad cycles) expected %02h",
                                 idx, frm[8:1], frm, bad, exp_b);
                    end
                    exp_rd[idx]++;
                end
            end
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (!((exp_rd[0] == exp_wr[0]) && (exp_rd[1] == exp_wr[1]) &&
                 (exp_rd[2] == exp_wr[2]) && (exp_rd[3] == exp_wr[3])) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d frames outstanding expected 0",
                     name, (exp_wr[0] - exp_rd[0]) + (exp_wr[1] - exp_rd[1]) +
                           (exp_wr[2] - exp_rd[2]) + (exp_wr[3] - exp_rd[3]));
        end
        repeat (6) @(negedge clk);
    endtask

    // Idle lines, the model's sticky flags, and the expected busy level.
    task automatic check_state(input int inst, input logic exp_busy, input string tag);
        if (inst == 0) begin
            chk({tag, "_host_tx"}, 32'(m_host_tx), 32'd1);
            chk({tag, "_wifi_tx"}, 32'(m_wifi_tx), 32'd1);
            chk({tag, "_h2w_ovf"}, 32'(m_h2w), 32'(exp_h2w[0]));
            chk({tag, "_w2h_ovf"}, 32'(m_w2h), 32'(exp_w2h[0]));
            chk({tag, "_frame_err"}, 32'(m_ferr), 32'(exp_ferr[0]));
            chk({tag, "_busy"}, 32'(m_busy), 32'(exp_busy));
        end else begin
            chk({tag, "_host_tx"}, 32'(o_host_tx), 32'd1);
            chk({tag, "_wifi_tx"}, 32'(o_wifi_tx), 32'd1);
            chk({tag, "_h2w_ovf"}, 32'(o_h2w), 32'(exp_h2w[1]));
            chk({tag, "_w2h_ovf"}, 32'(o_w2h), 32'(exp_w2h[1]));
            chk({tag, "_frame_err"}, 32'(o_ferr), 32'(exp_ferr[1]));
            chk({tag, "_busy"}, 32'(o_busy), 32'(exp_busy));
        end
    endtask

    initial begin
        #2_600_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t1, base, dly;
        for (int i = 0; i < 4; i++) begin
            exp_wr[i] = 0; exp_rd[i] = 0; starts[i] = 0; last_start[i] = 0;
            last_byte[i] = '0; last_frame[i] = '0;
        end
        for (int i = 0; i < 2; i++) begin
            exp_h2w[i] = 1'b0; exp_w2h[i] = 1'b0; exp_ferr[i] = 1'b0;
        end
        rst_n = 1'b0;
        m_host_rx = 1'b1; m_wifi_rx = 1'b1; o_host_rx = 1'b1; o_wifi_rx = 1'b1;
        #200;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_state(0, 1'b0, "reset_m");
        check_state(1, 1'b0, "reset_o");
        fork
            mon(0, CPB);
            mon(1, CPB);
            mon(2, O_TXCPB);
            mon(3, O_TXCPB);
        join_none

        // Single byte host->wifi; start bit due ~9.5 bit periods after the host start edge
        expect_byte(0, 8'hA5);
        send_byte(0, 8'hA5, CPB, 1'b1, t0);
        dly = last_start[0] - t0;
        n_tests++;
        if ((starts[0] != 1) || (dly < 9 * CPB + CPB / 2) || (dly > 9 * CPB + CPB / 2 + 8)) begin
            n_fail++;
            $display("FAIL single_latency: got %0d cycles (%0d starts) expected %0d..%0d",
                     dly, starts[0], 9 * CPB + CPB / 2, 9 * CPB + CPB / 2 + 8);
        end
        chk("single_busy_active", 32'(m_busy), 32'd1);
        wait_drain(12 * CPB, "single");
        chk("single_byte", 32'(last_byte[0]), 32'h0000_00A5);
        chk("single_frame_bits", 32'(last_frame[0]), 32'b11_0100_1010);
        check_state(0, 1'b0, "single");

        // Both directions at once
        expect_byte(0, 8'h55);
        expect_byte(1, 8'h3C);
        fork
            send_byte(0, 8'h55, CPB, 1'b1, t0);
            send_byte(1, 8'h3C, CPB, 1'b1, t1);
        join
        wait_drain(12 * CPB, "concurrent");
        chk("concurrent_wifi_tx", 32'(last_byte[0]), 32'h0000_0055);
        chk("concurrent_host_tx", 32'(last_byte[1]), 32'h0000_003C);
        check_state(0, 1'b0, "concurrent");

        // Framing error: byte discarded, flag sticky, next byte still forwarded
        base = starts[0];
        send_byte(0, 8'h81, CPB, 1'b0, t0);
        exp_ferr[0] = 1'b1;
        repeat (40) @(negedge clk);
        chk("ferr_no_output", 32'(starts[0]), 32'(base));
        check_state(0, 1'b0, "ferr");
        expect_byte(0, 8'h42);
        send_byte(0, 8'h42, CPB, 1'b1, t0);
        wait_drain(12 * CPB, "ferr_next");
        chk("ferr_next_byte", 32'(last_byte[0]), 32'h0000_0042);
        check_state(0, 1'b0, "ferr_next");

        // Overflow: one byte in flight plus 16 buffered survive, the 18th is dropped
        for (int i = 0; i < 17; i++) expect_byte(2, 8'(i));
        for (int i = 0; i < 18; i++) send_byte(2, 8'(i), O_RXCPB, 1'b1, t0);
        exp_h2w[1] = 1'b1;
        repeat (5) @(negedge clk);
        chk("ovf_flag_set", 32'(o_h2w), 32'd1);
        chk("ovf_busy", 32'(o_busy), 32'd1);
        wait_drain(40000, "ovf");
        chk("ovf_count", 32'(starts[2]), 32'd17);
        chk("ovf_last_byte", 32'(last_byte[2]), 32'h0000_0010);
        check_state(1, 1'b0, "ovf");

        // Reset during data bit 4: partial byte dropped, sticky flags cleared
        base = starts[0];
        send_partial(0, 8'hC6, CPB);
        rst_n = 1'b0;
        m_host_rx = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_wifi_tx", 32'(m_wifi_tx), 32'd1);
        chk("midrst_busy", 32'(m_busy), 32'd0);
        rst_n = 1'b1;
        exp_ferr[0] = 1'b0;
        exp_h2w[1]  = 1'b0;
        repeat (5) @(negedge clk);
        check_state(0, 1'b0, "midrst");
        check_state(1, 1'b0, "midrst_o");
        repeat (10 * CPB) @(negedge clk);
        chk("midrst_no_output", 32'(starts[0]), 32'(base));
        expect_byte(0, 8'h0F);
        send_byte(0, 8'h0F, CPB, 1'b1, t0);
        wait_drain(12 * CPB, "midrst_next");
        chk("midrst_next_byte", 32'(last_byte[0]), 32'h0000_000F);
        check_state(0, 1'b0, "midrst_next");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
